load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32 load/store unit: decodes one request at a time and runs it as a single
// AXI4-Lite read or write, returning sign/zero-extended load data or an error.
module load_store_unit #(
   parameter int   ADDR_W      = 32,
   parameter logic ALIGN_CHECK = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              resp_misaligned,
   output logic [ADDR_W-1:0] awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [31:0]       wdata,
   output logic [3:0]        wstrb,
   output logic              wvalid,
   input  logic              wready,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [31:0]       rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready
);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
   } state_t;

   state_t            state_reg, state_next;
   logic [2:0]        funct3_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [31:0]       wdata_reg;
   logic              aw_done_reg, w_done_reg;
   logic [31:0]       resp_rdata_reg;
   logic              resp_err_reg, resp_misaligned_reg;

   logic              req_legal, req_misaligned, req_bad, accept;
   logic              aw_hs, w_hs;
   logic [1:0]        off;
   logic [3:0]        store_strb;
   logic [31:0]       store_data, shifted, load_data;
   logic [ADDR_W-1:0] aligned_addr;

   // Request decode; misalignment only matters for otherwise legal operations.
   always_comb begin
      req_legal      = 1'b0;
      req_misaligned = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: req_legal = 1'b1;
         3'b100, 3'b101:         req_legal = !req_write;
         default:                req_legal = 1'b0;
      endcase
      if (ALIGN_CHECK) begin
         case (req_funct3[1:0])
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = |req_addr[1:0];
            default: req_misaligned = 1'b0;
         endcase
      end
      req_misaligned = req_misaligned && req_legal;
      req_bad        = !req_legal || req_misaligned;
   end

   assign accept       = req_valid && (state_reg == IDLE);
   assign aligned_addr = {addr_reg[ADDR_W-1:2], 2'b00};

   // Byte offset within the word; low bits are dropped for wider accesses.
   always_comb begin
      case (funct3_reg[1:0])
         2'b00:   off = addr_reg[1:0];
         2'b01:   off = {addr_reg[1], 1'b0};
         default: off = 2'b00;
      endcase
      case (funct3_reg[1:0])
         2'b00:   store_strb = 4'b0001 << off;
         2'b01:   store_strb = 4'b0011 << off;
         default: store_strb = 4'b1111;
      endcase
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign store_data[8*gi +: 8] =
         (funct3_reg[1:0] == 2'b00) ? wdata_reg[7:0] :
         (funct3_reg[1:0] == 2'b01) ? wdata_reg[8*(gi%2) +: 8] :
                                      wdata_reg[8*gi +: 8];
   end

   assign shifted = rdata >> {off, 3'b000};

   always_comb begin
      case (funct3_reg)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_data = {24'h0, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  load_data = {16'h0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   assign req_ready  = (state_reg == IDLE);
   assign awvalid    = (state_reg == WR_ADDR_DATA) && !aw_done_reg;
   assign wvalid     = (state_reg == WR_ADDR_DATA) && !w_done_reg;
   assign bready     = (state_reg == WR_RESP);
   assign arvalid    = (state_reg == RD_ADDR);
   assign rready     = (state_reg == RD_DATA);
   assign resp_valid = (state_reg == RESP);
   assign aw_hs      = awvalid && awready;
   assign w_hs       = wvalid && wready;

   assign awaddr          = awvalid ? aligned_addr : '0;
   assign araddr          = arvalid ? aligned_addr : '0;
   assign wdata           = wvalid ? store_data : 32'h0;
   assign wstrb           = wvalid ? store_strb : 4'h0;
   assign resp_rdata      = resp_rdata_reg;
   assign resp_err        = resp_err_reg;
   assign resp_misaligned = resp_misaligned_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (req_valid) begin
               if (req_bad)        state_next = RESP;
               else if (req_write) state_next = WR_ADDR_DATA;
               else                state_next = RD_ADDR;
            end
         end
         WR_ADDR_DATA: if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) state_next = WR_RESP;
         WR_RESP:      if (bvalid)  state_next = RESP;
         RD_ADDR:      if (arready) state_next = RD_DATA;
         RD_DATA:      if (rvalid)  state_next = RESP;
         default:      state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg           <= IDLE;
         funct3_reg          <= 3'b000;
         addr_reg            <= '0;
         wdata_reg           <= 32'h0;
         aw_done_reg         <= 1'b0;
         w_done_reg          <= 1'b0;
         resp_rdata_reg      <= 32'h0;
         resp_err_reg        <= 1'b0;
         resp_misaligned_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            funct3_reg  <= req_funct3;
            addr_reg    <= req_addr;
            wdata_reg   <= req_wdata;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            if (req_bad) begin
               resp_rdata_reg      <= 32'h0;
               resp_err_reg        <= 1'b1;
               resp_misaligned_reg <= req_misaligned;
            end
         end
         if (aw_hs) aw_done_reg <= 1'b1;
         if (w_hs)  w_done_reg  <= 1'b1;
         if (state_reg == WR_RESP && bvalid) begin
            resp_rdata_reg      <= 32'h0;
            resp_err_reg        <= (bresp != 2'b00);
            resp_misaligned_reg <= 1'b0;
         end
         if (state_reg == RD_DATA && rvalid) begin
            resp_rdata_reg      <= (rresp != 2'b00) ? 32'h0 : load_data;
            resp_err_reg        <= (rresp != 2'b00);
            resp_misaligned_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a configurable AXI4-Lite slave model
// serves the main instance; a second instance checks the ALIGN_CHECK=0 build.
module tb_load_store_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_valid0 = 1'b0;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;

   logic        req_ready, resp_valid, resp_err, resp_misaligned;
   logic [31:0] resp_rdata, awaddr, wdata, araddr;
   logic [3:0]  wstrb;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [1:0]  bresp = 2'b00, rresp = 2'b00;
   logic [31:0] rdata = 32'h0;

   logic        req_ready0, resp_valid0, resp_err0, resp_misaligned0;
   logic [31:0] resp_rdata0, awaddr0, wdata0, araddr0;
   logic [3:0]  wstrb0;
   logic        awvalid0, wvalid0, bready0, arvalid0, rready0;
   logic        one = 1'b1;
   logic [1:0]  okay = 2'b00;
   logic [31:0] rdata0 = 32'hCAFE_8001;

   load_store_unit #(.ADDR_W(32), .ALIGN_CHECK(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .resp_misaligned(resp_misaligned),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
      .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
      .rvalid(rvalid), .rready(rready)
   );

   load_store_unit #(.ADDR_W(32), .ALIGN_CHECK(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
      .resp_misaligned(resp_misaligned0),
      .awaddr(awaddr0), .awvalid(awvalid0), .awready(one), .wdata(wdata0), .wstrb(wstrb0),
      .wvalid(wvalid0), .wready(one), .bresp(okay), .bvalid(one), .bready(bready0),
      .araddr(araddr0), .arvalid(arvalid0), .arready(one), .rdata(rdata0), .rresp(okay),
      .rvalid(one), .rready(rready0)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        mis;
      int          lat;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } exp_t;

   exp_t exp_q[$];
   int vectors = 0, miscompares = 0;

   int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic [31:0] rdata_cfg = 32'h0;

   // AXI slave model: each ready/valid appears after its configured delay.
   always @(negedge clk) begin
      if (!rst_n) begin
         awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
         aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      end else begin
         if (awvalid) begin
            if (aw_wait >= aw_delay) awready = 1; else begin awready = 0; aw_wait++; end
         end else begin awready = 0; aw_wait = 0; end
         if (wvalid) begin
            if (w_wait >= w_delay) wready = 1; else begin wready = 0; w_wait++; end
         end else begin wready = 0; w_wait = 0; end
         if (arvalid) begin
            if (ar_wait >= ar_delay) arready = 1; else begin arready = 0; ar_wait++; end
         end else begin arready = 0; ar_wait = 0; end
         if (bready) begin
            if (b_wait >= b_delay) begin bvalid = 1; bresp = bresp_cfg; end
            else begin bvalid = 0; b_wait++; end
         end else begin bvalid = 0; b_wait = 0; end
         if (rready) begin
            if (r_wait >= r_delay) begin rvalid = 1; rdata = rdata_cfg; rresp = rresp_cfg; end
            else begin rvalid = 0; r_wait++; end
         end else begin rvalid = 0; r_wait = 0; end
      end
   end

   int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, resp_cnt = 0, axi_cycles = 0;
   logic [31:0] last_awaddr = 0, last_wdata = 0, last_araddr = 0;
   logic [3:0]  last_wstrb = 0;
   logic [31:0] last_araddr0 = 0, last_awaddr0 = 0;
   logic [3:0]  last_wstrb0 = 0;

   always @(posedge clk) begin
      if (rst_n) begin
         if (awvalid && awready) begin aw_cnt++; last_awaddr = awaddr; end
         if (wvalid && wready) begin w_cnt++; last_wdata = wdata; last_wstrb = wstrb; end
         if (arvalid && arready) begin ar_cnt++; last_araddr = araddr; end
         if (awvalid || wvalid || arvalid) axi_cycles++;
         if (resp_valid) resp_cnt++;
         if (arvalid0) last_araddr0 = araddr0;
         if (awvalid0) last_awaddr0 = awaddr0;
         if (wvalid0) last_wstrb0 = wstrb0;
      end
   end

   function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[8*addr[1:0] +: 8];
      h = addr[1] ? rd[31:16] : rd[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'h0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'h0, h};
         default: return rd;
      endcase
   endfunction

   function automatic logic [3:0] strb_model(input logic [2:0] f3, input logic [31:0] addr);
      case (f3)
         3'b000:  return 4'b0001 << addr[1:0];
         3'b001:  return addr[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] wd);
      case (f3)
         3'b000:  return {4{wd[7:0]}};
         3'b001:  return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   task automatic send_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
      req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(output int cyc);
      cyc = 1;
      while (resp_valid !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({awvalid, wvalid, bready, arvalid, rready, resp_valid, resp_err, resp_misaligned} !== 8'h00) begin
         $display("FAIL reset_flags got=%b required=00000000",
                  {awvalid, wvalid, bready, arvalid, rready, resp_valid, resp_err, resp_misaligned});
         miscompares++;
      end
      vectors++;
      if ({resp_rdata, awaddr, araddr, wdata, wstrb} !== 132'h0) begin
         $display("FAIL reset_data rdata=%h awaddr=%h araddr=%h wdata=%h wstrb=%b required all 0",
                  resp_rdata, awaddr, araddr, wdata, wstrb);
         miscompares++;
      end
      vectors++;
      if (req_ready !== 1'b1) begin
         $display("FAIL reset_req_ready got=%b required=1", req_ready);
         miscompares++;
      end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({req_ready, resp_valid, awvalid, arvalid} !== 4'b1000) begin
         $display("FAIL post_reset_idle got=%b required=1000", {req_ready, resp_valid, awvalid, arvalid});
         miscompares++;
      end
   endtask

   task automatic test_loads();
      logic [2:0]  f3s [6];
      logic [31:0] addrs [6], rds [6], exps [6];
      exp_t e;
      int cyc, ar0;
      f3s   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
      addrs = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h104};
      rds   = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h80FF_1234, 32'h80FF_1234, 32'h0000_7F00, 32'hDEAD_BEEF};
      exps  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h0000_007F, 32'hDEAD_BEEF};
      for (int i = 0; i < 6; i++) begin
         rdata_cfg = rds[i];
         exp_q.push_back('{exps[i], 1'b0, 1'b0, 3, 32'h0, 4'h0});
         ar0 = ar_cnt;
         send_req(1'b0, f3s[i], addrs[i], 32'h0);
         wait_resp(cyc);
         e = exp_q.pop_front();
         vectors++;
         if (resp_valid !== 1'b1 || {resp_rdata, resp_err, resp_misaligned} !== {e.rdata, e.err, e.mis}) begin
            $display("FAIL load[%0d] valid=%b rdata=%h err=%b mis=%b required rdata=%h err=%b mis=%b",
                     i, resp_valid, resp_rdata, resp_err, resp_misaligned, e.rdata, e.err, e.mis);
            miscompares++;
         end
         vectors++;
         if (cyc != e.lat || ar_cnt != ar0 + 1 || last_araddr !== (addrs[i] & 32'hFFFF_FFFC)) begin
            $display("FAIL load_axi[%0d] latency=%0d ar_count=%0d araddr=%h required latency=%0d ar_count=%0d araddr=%h",
                     i, cyc, ar_cnt - ar0, last_araddr, e.lat, 1, addrs[i] & 32'hFFFF_FFFC);
            miscompares++;
         end
         @(negedge clk);
         vectors++;
         if (resp_valid !== 1'b0) begin
            $display("FAIL load_pulse[%0d] resp_valid=%b required 0", i, resp_valid);
            miscompares++;
         end
      end
   endtask

   task automatic test_stores();
      logic [2:0]  f3s [5];
      logic [31:0] addrs [5], wds [5], expd [5];
      logic [3:0]  exps [5];
      int awd [5], wd_d [5];
      exp_t e;
      int cyc, aw0, w0, r0;
      f3s   = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b001};
      addrs = '{32'h202, 32'h301, 32'h400, 32'h403, 32'h500};
      wds   = '{32'h1234_ABCD, 32'h0000_00EF, 32'hA5A5_5A5A, 32'h1234_5678, 32'hFFFF_8001};
      expd  = '{32'hABCD_ABCD, 32'hEFEF_EFEF, 32'hA5A5_5A5A, 32'h7878_7878, 32'h8001_8001};
      exps  = '{4'b1100, 4'b0010, 4'b1111, 4'b1000, 4'b0011};
      awd   = '{0, 2, 0, 1, 3};
      wd_d  = '{1, 0, 0, 1, 1};
      for (int i = 0; i < 5; i++) begin
         aw_delay = awd[i]; w_delay = wd_d[i];
         exp_q.push_back('{32'h0, 1'b0, 1'b0, 3 + ((awd[i] > wd_d[i]) ? awd[i] : wd_d[i]), expd[i], exps[i]});
         aw0 = aw_cnt; w0 = w_cnt; r0 = resp_cnt;
         send_req(1'b1, f3s[i], addrs[i], wds[i]);
         wait_resp(cyc);
         e = exp_q.pop_front();
         vectors++;
         if (resp_valid !== 1'b1 || {resp_err, resp_misaligned} !== {e.err, e.mis} || cyc != e.lat) begin
            $display("FAIL store[%0d] valid=%b err=%b mis=%b latency=%0d required err=0 mis=0 latency=%0d",
                     i, resp_valid, resp_err, resp_misaligned, cyc, e.lat);
            miscompares++;
         end
         vectors++;
         if (last_awaddr !== (addrs[i] & 32'hFFFF_FFFC) || last_wdata !== e.wdata || last_wstrb !== e.wstrb) begin
            $display("FAIL store_beat[%0d] awaddr=%h wdata=%h wstrb=%b required awaddr=%h wdata=%h wstrb=%b",
                     i, last_awaddr, last_wdata, last_wstrb, addrs[i] & 32'hFFFF_FFFC, e.wdata, e.wstrb);
            miscompares++;
         end
         @(negedge clk);
         vectors++;
         if (aw_cnt != aw0 + 1 || w_cnt != w0 + 1 || resp_cnt != r0 + 1 || resp_valid !== 1'b0) begin
            $display("FAIL store_counts[%0d] aw=%0d w=%0d resp=%0d valid_after=%b required 1 1 1 0",
                     i, aw_cnt - aw0, w_cnt - w0, resp_cnt - r0, resp_valid);
            miscompares++;
         end
      end
      aw_delay = 0; w_delay = 0;
   endtask

   // Requests rejected before any bus traffic: misaligned and illegal funct3.
   task automatic test_rejects();
      logic        wrs [8], mis [8];
      logic [2:0]  f3s [8];
      logic [31:0] addrs [8];
      exp_t e;
      int cyc, ax0;
      wrs   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      f3s   = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b011, 3'b110, 3'b100, 3'b011};
      addrs = '{32'h101, 32'h103, 32'h202, 32'h201, 32'h100, 32'h102, 32'h200, 32'h204};
      mis   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back('{32'h0, 1'b1, mis[i], 1, 32'h0, 4'h0});
         ax0 = axi_cycles;
         send_req(wrs[i], f3s[i], addrs[i], 32'hFFFF_FFFF);
         wait_resp(cyc);
         e = exp_q.pop_front();
         vectors++;
         if (resp_valid !== 1'b1 || cyc != e.lat ||
             {resp_rdata, resp_err, resp_misaligned} !== {e.rdata, e.err, e.mis}) begin
            $display("FAIL reject[%0d] valid=%b latency=%0d rdata=%h err=%b mis=%b required latency=1 rdata=0 err=1 mis=%b",
                     i, resp_valid, cyc, resp_rdata, resp_err, resp_misaligned, e.mis);
            miscompares++;
         end
         @(negedge clk);
         vectors++;
         if (axi_cycles != ax0 || resp_valid !== 1'b0) begin
            $display("FAIL reject_no_axi[%0d] axi_valid_cycles=%0d resp_valid=%b required 0 0",
                     i, axi_cycles - ax0, resp_valid);
            miscompares++;
         end
      end
   endtask

   task automatic test_bus_errors();
      logic        wrs [4];
      logic [2:0]  f3s [4];
      logic [1:0]  codes [4];
      exp_t e;
      int cyc;
      wrs   = '{1'b1, 1'b0, 1'b1, 1'b0};
      f3s   = '{3'b010, 3'b010, 3'b000, 3'b100};
      codes = '{2'b10, 2'b11, 2'b01, 2'b10};
      rdata_cfg = 32'h1234_5678;
      for (int i = 0; i < 4; i++) begin
         bresp_cfg = wrs[i] ? codes[i] : 2'b00;
         rresp_cfg = wrs[i] ? 2'b00 : codes[i];
         exp_q.push_back('{32'h0, 1'b1, 1'b0, 3, 32'h0, 4'h0});
         send_req(wrs[i], f3s[i], 32'h600 + 32'(4 * i), 32'h5555_AAAA);
         wait_resp(cyc);
         e = exp_q.pop_front();
         vectors++;
         if (resp_valid !== 1'b1 || {resp_rdata, resp_err, resp_misaligned} !== {e.rdata, e.err, e.mis}) begin
            $display("FAIL bus_err[%0d] valid=%b rdata=%h err=%b mis=%b required rdata=0 err=1 mis=0",
                     i, resp_valid, resp_rdata, resp_err, resp_misaligned);
            miscompares++;
         end
         @(negedge clk);
      end
      bresp_cfg = 2'b00; rresp_cfg = 2'b00;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int n, cyc, r0;
      r_delay = 12;
      send_req(1'b0, 3'b010, 32'h700, 32'h0);
      n = 0;
      while (rready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      vectors++;
      if (rready !== 1'b1) begin
         $display("FAIL midreset_reach_rd_data rready=%b required 1", rready);
         miscompares++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      vectors++;
      if ({awvalid, wvalid, bready, arvalid, rready, resp_valid, req_ready} !== 7'b0000001) begin
         $display("FAIL midreset_abort got=%b required=0000001",
                  {awvalid, wvalid, bready, arvalid, rready, resp_valid, req_ready});
         miscompares++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      r_delay = 0;
      r0 = resp_cnt;
      repeat (15) @(negedge clk);
      vectors++;
      if (resp_cnt != r0) begin
         $display("FAIL midreset_stray_resp count=%0d required 0", resp_cnt - r0);
         miscompares++;
      end
      rdata_cfg = 32'h0BAD_F00D;
      exp_q.push_back('{32'h0BAD_F00D, 1'b0, 1'b0, 3, 32'h0, 4'h0});
      send_req(1'b0, 3'b010, 32'h704, 32'h0);
      wait_resp(cyc);
      e = exp_q.pop_front();
      vectors++;
      if (resp_valid !== 1'b1 || cyc != e.lat || {resp_rdata, resp_err} !== {e.rdata, e.err}) begin
         $display("FAIL midreset_recover valid=%b latency=%0d rdata=%h err=%b required latency=3 rdata=%h err=0",
                  resp_valid, cyc, resp_rdata, resp_err, e.rdata);
         miscompares++;
      end
      @(negedge clk);
   endtask

   task automatic test_align_off();
      logic        wrs [4];
      logic [2:0]  f3s [4];
      logic [31:0] addrs [4], exps [4];
      exp_t e;
      int cyc;
      wrs   = '{1'b0, 1'b0, 1'b0, 1'b1};
      f3s   = '{3'b010, 3'b001, 3'b101, 3'b010};
      addrs = '{32'h101, 32'h103, 32'h101, 32'h202};
      exps  = '{32'hCAFE_8001, 32'hFFFF_CAFE, 32'h0000_8001, 32'h0};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{exps[i], 1'b0, 1'b0, 3, 32'h0, 4'b1111});
         req_write = wrs[i]; req_funct3 = f3s[i]; req_addr = addrs[i]; req_wdata = 32'h1357_9BDF;
         req_valid0 = 1'b1;
         @(negedge clk);
         req_valid0 = 1'b0;
         cyc = 1;
         while (resp_valid0 !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
         e = exp_q.pop_front();
         vectors++;
         if (resp_valid0 !== 1'b1 || cyc != e.lat ||
             {resp_rdata0, resp_err0, resp_misaligned0} !== {e.rdata, e.err, e.mis}) begin
            $display("FAIL noalign[%0d] valid=%b latency=%0d rdata=%h err=%b mis=%b required latency=3 rdata=%h err=0 mis=0",
                     i, resp_valid0, cyc, resp_rdata0, resp_err0, resp_misaligned0, e.rdata);
            miscompares++;
         end
         vectors++;
         if (!wrs[i] && last_araddr0 !== (addrs[i] & 32'hFFFF_FFFC)) begin
            $display("FAIL noalign_araddr[%0d] got=%h required=%h", i, last_araddr0, addrs[i] & 32'hFFFF_FFFC);
            miscompares++;
         end else if (wrs[i] && (last_awaddr0 !== (addrs[i] & 32'hFFFF_FFFC) || last_wstrb0 !== e.wstrb)) begin
            $display("FAIL noalign_aw[%0d] awaddr=%h wstrb=%b required awaddr=%h wstrb=1111",
                     i, last_awaddr0, last_wstrb0, addrs[i] & 32'hFFFF_FFFC);
            miscompares++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr, wd;
      int k, cyc, mx;
      for (int i = 0; i < 12; i++) begin
         wr = 1'($urandom_range(0, 1));
         k  = int'($urandom_range(0, wr ? 2 : 4));
         f3 = 3'((k < 3) ? k : k + 1);
         addr = $urandom & 32'h0000_FFFC;
         if (f3[1:0] == 2'b00)      addr[1:0] = 2'($urandom_range(0, 3));
         else if (f3[1:0] == 2'b01) addr[1]   = 1'($urandom_range(0, 1));
         wd = $urandom;
         rdata_cfg = $urandom;
         aw_delay = int'($urandom_range(0, 2)); w_delay = int'($urandom_range(0, 2));
         b_delay  = int'($urandom_range(0, 2)); ar_delay = int'($urandom_range(0, 2));
         r_delay  = int'($urandom_range(0, 2));
         mx = (aw_delay > w_delay) ? aw_delay : w_delay;
         if (wr) exp_q.push_back('{32'h0, 1'b0, 1'b0, 3 + mx + b_delay, wdata_model(f3, wd), strb_model(f3, addr)});
         else    exp_q.push_back('{load_model(f3, addr, rdata_cfg), 1'b0, 1'b0, 3 + ar_delay + r_delay, 32'h0, 4'h0});
         send_req(wr, f3, addr, wd);
         wait_resp(cyc);
         e = exp_q.pop_front();
         vectors++;
         if (resp_valid !== 1'b1 || cyc != e.lat ||
             {resp_rdata, resp_err, resp_misaligned} !== {e.rdata, e.err, e.mis}) begin
            $display("FAIL b2b[%0d] wr=%b f3=%b addr=%h valid=%b latency=%0d rdata=%h err=%b required latency=%0d rdata=%h err=0",
                     i, wr, f3, addr, resp_valid, cyc, resp_rdata, resp_err, e.lat, e.rdata);
            miscompares++;
         end
         if (wr) begin
            vectors++;
            if (last_wdata !== e.wdata || last_wstrb !== e.wstrb) begin
               $display("FAIL b2b_beat[%0d] wdata=%h wstrb=%b required wdata=%h wstrb=%b",
                        i, last_wdata, last_wstrb, e.wdata, e.wstrb);
               miscompares++;
            end
         end
         @(negedge clk);
      end
      aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
   endtask

   initial begin
      test_reset();
      test_loads();
      test_stores();
      test_rejects();
      test_bus_errors();
      test_reset_mid();
      test_align_off();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
